// File: rtl/mvm_pkg.sv
`default_nettype none
// ============================================================================
// mvm_pkg : shared types and default sizes for the matrix-vector unit blocks.
// Rev 1.0
// ============================================================================
package mvm_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } state_t;

  localparam int MVM_WIDTH = 16;
  localparam int MVM_N     = 16;

endpackage
`default_nettype wire

// File: rtl/mvm_vector_source_mem.sv
`default_nettype none
// ============================================================================
// mvm_vector_source_mem : simple dual-port buffer, registered read (1 cycle).
// Rev 1.0
// ============================================================================
module mvm_vector_source_mem #(
  parameter int WIDTH = 16,
  parameter int SIZE  = 16
) (
  input  logic                      clk,
  input  logic                      i_wr_en,
  input  logic [$clog2(SIZE)-1:0]   i_wr_addr,
  input  logic [WIDTH-1:0]          i_wr_data,
  input  logic                      i_rd_en,
  input  logic [$clog2(SIZE)-1:0]   i_rd_addr,
  output logic [WIDTH-1:0]          o_rd_data
);

  logic [WIDTH-1:0] r_mem [SIZE];
  logic [WIDTH-1:0] r_rd_data;

  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
    if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/mvm_vector_source.sv
`default_nettype none
// ============================================================================
// mvm_vector_source : buffers one N-element vector and streams it to the MVM
// input port over valid/ready. Rev 1.0
// ============================================================================
module mvm_vector_source
  import mvm_pkg::*;
#(
  parameter int WIDTH = MVM_WIDTH,
  parameter int N     = MVM_N
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [$clog2(N)-1:0]   wr_addr,
  input  logic [WIDTH-1:0]       wr_data,
  output logic                   wr_err,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_last
);

  localparam int ADDR_W = $clog2(N);
  localparam int CNT_W  = ADDR_W + 1;
  localparam logic [CNT_W-1:0] C_N    = CNT_W'(N);
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(N - 1);

  state_t           r_state;
  logic             r_busy;
  logic             r_done;
  logic             r_wr_err;
  logic             r_primed;
  logic [CNT_W-1:0] r_rd_addr;
  logic [CNT_W-1:0] r_sent_cnt;
  logic             r_dvld;
  logic [WIDTH-1:0] r_fifo [2];
  logic             r_wptr;
  logic             r_rptr;
  logic [1:0]       r_occ;

  logic             w_mem_wr_en;
  logic             w_rd_en;
  logic             w_push;
  logic             w_pop;
  logic [1:0]       w_level;
  logic [WIDTH-1:0] w_rd_data;

  assign w_mem_wr_en = wr_en && (r_state == IDLE);
  assign w_push      = r_dvld;
  assign w_pop       = (r_occ != 2'd0) && out_ready;
  // An element leaving this cycle frees its slot, which keeps the stream gap-free.
  assign w_level     = r_occ + {1'b0, r_dvld} - {1'b0, w_pop};
  assign w_rd_en     = (r_state == STREAM) && r_primed && (r_rd_addr < C_N) && (w_level < 2'd2);

  mvm_vector_source_mem #(
    .WIDTH (WIDTH),
    .SIZE  (N)
  ) u_buf (
    .clk       (clk),
    .i_wr_en   (w_mem_wr_en),
    .i_wr_addr (wr_addr),
    .i_wr_data (wr_data),
    .i_rd_en   (w_rd_en),
    .i_rd_addr (r_rd_addr[ADDR_W-1:0]),
    .o_rd_data (w_rd_data)
  );

  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wptr] <= w_rd_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_wr_err   <= 1'b0;
      r_primed   <= 1'b0;
      r_rd_addr  <= '0;
      r_sent_cnt <= '0;
      r_dvld     <= 1'b0;
      r_wptr     <= 1'b0;
      r_rptr     <= 1'b0;
      r_occ      <= 2'd0;
    end else begin
      r_done   <= 1'b0;
      r_wr_err <= wr_en && (r_state != IDLE);
      r_dvld   <= w_rd_en;
      r_occ    <= r_occ + {1'b0, w_push} - {1'b0, w_pop};
      if (w_push)  r_wptr    <= ~r_wptr;
      if (w_rd_en) r_rd_addr <= r_rd_addr + 1'b1;
      if (w_pop) begin
        r_rptr     <= ~r_rptr;
        r_sent_cnt <= r_sent_cnt + 1'b1;
      end

      case (r_state)
        IDLE: begin
          if (start) begin
            r_state    <= STREAM;
            r_busy     <= 1'b1;
            r_rd_addr  <= '0;
            r_sent_cnt <= '0;
            r_primed   <= 1'b0;
          end
        end
        STREAM: begin
          // One settling cycle before the first read places out_valid on the third edge.
          r_primed <= 1'b1;
          if (w_rd_en && (r_rd_addr == C_LAST)) r_state <= DRAIN;
        end
        DRAIN: begin
          if (w_pop && (r_sent_cnt == C_LAST)) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign wr_err    = r_wr_err;
  assign out_valid = (r_occ != 2'd0);
  assign out_data  = r_fifo[r_rptr];
  assign out_last  = out_valid && (r_sent_cnt == C_LAST);

endmodule
`default_nettype wire
